sort_array_loader: RTL and testbench

- Upstream feeder for the bubble-sort engine.
- Accepts a stream of N words over a valid/ready handshake and writes them into consecutive addresses 0..N-1 of the sorter's data memory.
- After the last write it issues a one-cycle start pulse to the sorter, then holds off new input until the sorter reports done.
- Runs back-to-back sort jobs without software intervention.

---
 rtl/sort_array_loader.sv | 97 +++++++++
 tb/tb_sort_array_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_array_loader.sv
// sort_array_loader: upstream feeder for the bubble-sort engine.
// Takes N words over a valid/ready stream, writes them to sorter memory
// addresses 0..N-1, pulses sort_start once, then blocks input until the
// sorter reports done. Back-to-back jobs run without software help.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      producer has a word on in_data
//   in_data       word to store
//   in_ready      loader accepts a word this cycle (from registered state only)
//   mem_wr        write strobe to sorter data memory
//   mem_addr      write address (holds its value when mem_wr is low)
//   mem_wdata     write data (holds its value when mem_wr is low)
//   sort_start    one-cycle start pulse to the sorter
//   sort_done     sorter finished (level or pulse)
//   busy          high from first accepted word until sort_done is taken
//   job_count     completed sort jobs, wraps 255 -> 0
module sort_array_loader #(
  parameter int unsigned N  = 10,
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic          sort_start,
  input  logic          sort_done,
  output logic          busy,
  output logic [7:0]    job_count
);

  typedef enum logic [1:0] {StLoad, StFlush, StStart, StWait} state_e;

  localparam logic [AW-1:0] LastPtr = AW'(N - 1);

  state_e        state_q;
  logic [AW-1:0] ptr_q;

  // No combinational path from in_valid.
  assign in_ready = (state_q == StLoad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      ptr_q      <= '0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      sort_start <= 1'b0;
      busy       <= 1'b0;
      job_count  <= '0;
    end else begin
      mem_wr     <= 1'b0;
      sort_start <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            mem_wr    <= 1'b1;
            mem_addr  <= ptr_q;
            mem_wdata <= in_data;
            busy      <= 1'b1;
            if (ptr_q == LastPtr) begin
              ptr_q   <= '0;
              state_q <= StFlush;
            end else begin
              ptr_q <= ptr_q + AW'(1);
            end
          end
        end
        // The write of the last element is on the memory port here; raise
        // the start pulse so it is visible during StStart.
        StFlush: begin
          sort_start <= 1'b1;
          state_q    <= StStart;
        end
        // sort_done ignored here: it may be a stale level from the last job.
        StStart: begin
          state_q <= StWait;
        end
        StWait: begin
          if (sort_done) begin
            state_q   <= StLoad;
            busy      <= 1'b0;
            job_count <= job_count + 8'd1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_array_loader.sv
// Randomized scoreboard bench for sort_array_loader.
module tb_sort_array_loader;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          sort_start;
  logic          sort_done;
  logic          busy;
  logic [7:0]    job_count;

  sort_array_loader #(.N(N), .W(W), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .sort_start (sort_start),
    .sort_done  (sort_done),
    .busy       (busy),
    .job_count  (job_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  wr_t           wq[$];     // expected writes with the cycle they must appear
  int            sq[$];     // cycles on which sort_start must be high
  int            cyc       = 0;
  bit            m_live    = 0;
  bit            m_loading = 1;
  bit            m_busy    = 0;
  logic [7:0]    m_jobs    = '0;
  int            m_ptr     = 0;
  int            done_from = 0;
  logic [AW-1:0] m_addr    = '0;
  logic [W-1:0]  m_data    = '0;
  int            starts    = 0;

  // Negedge: outputs from the last posedge are settled, and the inputs seen
  // here are exactly what the next posedge will sample.
  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      bit exp_wr;
      bit exp_st;
      exp_st = (sq.size() > 0) && (sq[0] == cyc);
      if (exp_st) void'(sq.pop_front());
      chk("sort_start", sort_start, exp_st);
      if (sort_start) starts++;
      exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("mem_wr", mem_wr, exp_wr);
      if (exp_wr) begin
        m_addr = wq[0].addr;
        m_data = wq[0].data;
        void'(wq.pop_front());
      end
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
      chk("in_ready", in_ready, m_loading);
      chk("busy", busy, m_busy);
      chk("job_count", job_count, m_jobs);
    end
    if (rst) begin
      m_live    = 1;
      m_loading = 1;
      m_busy    = 0;
      m_jobs    = '0;
      m_ptr     = 0;
      m_addr    = '0;
      m_data    = '0;
      wq.delete();
      sq.delete();
    end else if (m_live && m_loading && in_valid) begin
      wq.push_back('{cyc + 1, AW'(m_ptr), in_data});
      m_busy = 1;
      m_ptr++;
      if (m_ptr == N) begin
        m_ptr     = 0;
        m_loading = 0;
        sq.push_back(cyc + 2);
        done_from = cyc + 3;  // done sampled during flush/start is ignored
      end
    end else if (m_live && !m_loading && cyc >= done_from && sort_done) begin
      m_loading = 1;
      m_busy    = 0;
      m_jobs    = m_jobs + 8'd1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid always, 1: gapped 1,0,0, 2: random, 3: fixed test vector
  task automatic load_job(input int mode);
    int got = 0;
    int k = 0;
    logic [W-1:0] vec [N];
    vec = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd0, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
    while (got < int'(N) && k < 1000) begin
      case (mode)
        1:       in_valid = (k % 3 == 0);
        2:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      in_data = (mode == 3) ? vec[got] : W'($urandom);
      if (in_valid && in_ready) got++;
      step();
      k++;
    end
    in_valid = 1'b0;
    if (got < int'(N)) chk("load_timeout", got, N);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!sort_start && k < 50) begin
      step();
      k++;
    end
    if (!sort_start) chk("start_timeout", 32'd0, 32'd1);
  endtask

  // Pulse done once in S_WAIT after `delay` cycles, with junk input meanwhile.
  task automatic run_done(input int delay);
    wait_start();
    step();
    for (int i = 0; i < delay; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      step();
    end
    in_valid  = 1'b0;
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
  endtask

  initial begin
    int s0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sort_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Fixed vector, valid held high.
    load_job(3);
    run_done(4);
    // Gapped input.
    load_job(1);
    run_done(4);

    // Stale done level held from before S_START.
    load_job(0);
    sort_done = 1'b1;
    wait_start();
    for (int k = 0; k < 20 && busy; k++) step();
    sort_done = 1'b0;
    repeat (20) step();
    sort_done = 1'b1;  // arrives in S_LOAD: ignored
    step();
    sort_done = 1'b0;

    // Done low through S_START, long wait.
    load_job(0);
    run_done(20);

    // Reset mid-load after 4 accepts.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s0 = starts;
    repeat (3) step();
    chk("no_start_after_reset", starts, s0);
    load_job(0);
    run_done(4);

    // Randomized back-to-back jobs.
    for (int j = 0; j < 12; j++) begin
      load_job(2);
      run_done($urandom_range(0, 8));
    end

    // job_count wrap.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 256; j++) begin
      load_job(0);
      run_done(0);
    end
    step();
    chk("job_count_wrap", job_count, 32'd0);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
